// File: rtl/id_rf_pkg.sv
// id_rf_pkg: shared definitions for the decode/register-fetch stage.
//   - ex_mode_t : constant extender modes selected by ex_ctrl
//   - DEF_*     : default datapath width, register count and raw constant width
//   - extend()  : constant extender, computed on an EXT_MAX_W-bit vector and
//                 truncated by the caller to its own WIDTH
// Optional build macro used by this slice: ID_RF_R0_ZERO_EN (register 0
// hardwired to zero; see banco_registro_param).
package id_rf_pkg;

  typedef enum logic [1:0] {
    EX_ZERO = 2'b00,
    EX_SIGN = 2'b01,
    EX_HIGH = 2'b10,
    EX_SHL1 = 2'b11
  } ex_mode_t;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_NREGS   = 8;
  localparam int DEF_CONST_W = 11;

  // Upper bound on WIDTH supported by extend(); lets one function serve
  // every parametrisation of the stage.
  localparam int EXT_MAX_W = 64;

  // Builds all four extender results with masks so the bit positions can
  // depend on the caller's width/const_w without a parametrised function.
  // Bits above the caller's width are don't-care and get truncated away.
  function automatic logic [EXT_MAX_W-1:0] extend(
    input ex_mode_t               mode,
    input logic [EXT_MAX_W-1:0]   raw,
    input int                     width,
    input int                     const_w
  );
    logic [EXT_MAX_W-1:0] cmask;
    logic [EXT_MAX_W-1:0] hmask;
    logic [EXT_MAX_W-1:0] zext;
    logic [EXT_MAX_W-1:0] sext;
    logic [EXT_MAX_W-1:0] res;
    logic                 sign_bit;
    cmask    = (EXT_MAX_W'(1) << const_w) - EXT_MAX_W'(1);
    hmask    = (EXT_MAX_W'(1) << (width / 2)) - EXT_MAX_W'(1);
    zext     = raw & cmask;
    sign_bit = |(raw & (EXT_MAX_W'(1) << (const_w - 1)));
    sext     = sign_bit ? (zext | ~cmask) : zext;
    case (mode)
      EX_ZERO: res = zext;
      EX_SIGN: res = sext;
      EX_HIGH: res = (raw & hmask) << (width / 2);
      default: res = sext << 1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/id_rf_if.sv
// id_rf_if: decode-side, writeback and execute-side signals of id_rf_stage.
//   decode   : in_valid, in_ready, sel_a, sel_b, ex_ctrl, ex_const
//   writeback: wb_en, wb_sel, wb_src_md, wb_ula, wb_md
//   execute  : out_valid, out_ready, out_a, out_b, out_const
// Modports: slave = the stage itself, master = whatever drives the stage.
interface id_rf_if
  import id_rf_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREGS   = DEF_NREGS,
  parameter int CONST_W = DEF_CONST_W
);
  localparam int SEL_W = $clog2(NREGS);

  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   sel_a;
  logic [SEL_W-1:0]   sel_b;
  logic [1:0]         ex_ctrl;
  logic [CONST_W-1:0] ex_const;
  logic               wb_en;
  logic [SEL_W-1:0]   wb_sel;
  logic               wb_src_md;
  logic [WIDTH-1:0]   wb_ula;
  logic [WIDTH-1:0]   wb_md;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_a;
  logic [WIDTH-1:0]   out_b;
  logic [WIDTH-1:0]   out_const;

  modport slave (
    input  in_valid, sel_a, sel_b, ex_ctrl, ex_const,
    input  wb_en, wb_sel, wb_src_md, wb_ula, wb_md,
    input  out_ready,
    output in_ready, out_valid, out_a, out_b, out_const
  );

  modport master (
    output in_valid, sel_a, sel_b, ex_ctrl, ex_const,
    output wb_en, wb_sel, wb_src_md, wb_ula, wb_md,
    output out_ready,
    input  in_ready, out_valid, out_a, out_b, out_const
  );
endinterface

// File: rtl/id_rf_stage_banco.sv
// banco_registro_param: NREGS x WIDTH register bank.
//   clock, reset       : rising-edge clock, async active-high clear of all regs
//   we, waddr, wdata   : single write port
//   raddr_a/b, rdata_a/b: two combinational read ports with write-through
//                         bypass (a same-cycle write to the read address is
//                         returned instead of the stored value)
// With ID_RF_R0_ZERO_EN defined, register 0 reads as zero, ignores writes
// and is excluded from the bypass.
module banco_registro_param
  import id_rf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int SEL_W = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [SEL_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [SEL_W-1:0] raddr_a,
  input  logic [SEL_W-1:0] raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_ok;

`ifdef ID_RF_R0_ZERO_EN
  assign wr_ok = we && (waddr != '0);
`else
  assign wr_ok = we;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Bypass uses wr_ok, so a suppressed write to R0 is never forwarded.
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    if (wr_ok && waddr == raddr_a) rdata_a = wdata;
    if (wr_ok && waddr == raddr_b) rdata_b = wdata;
`ifdef ID_RF_R0_ZERO_EN
    if (raddr_a == '0) rdata_a = '0;
    if (raddr_b == '0) rdata_b = '0;
`endif
  end

endmodule

// File: rtl/id_rf_stage.sv
// id_rf_stage: decode/register-fetch stage between decode and execute.
//   clock, reset : rising-edge clock, async active-high reset
//   bus (slave)  : decode fields in (valid/ready), writeback from ULA/MD,
//                  registered operands A/B and extended constant out
//                  (valid/ready)
// The writeback mux and the output pipeline register live here; storage is in
// banco_registro_param. Build macro ID_RF_R0_ZERO_EN hardwires register 0.
module id_rf_stage
  import id_rf_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREGS   = DEF_NREGS,
  parameter int CONST_W = DEF_CONST_W
) (
  input logic    clock,
  input logic    reset,
  id_rf_if.slave bus
);

  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] const_ext;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic             valid_q;
  logic             accept;

  assign wdata = bus.wb_src_md ? bus.wb_md : bus.wb_ula;

  banco_registro_param #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_bank (
    .clock   (clock),
    .reset   (reset),
    .we      (bus.wb_en),
    .waddr   (bus.wb_sel),
    .wdata   (wdata),
    .raddr_a (bus.sel_a),
    .raddr_b (bus.sel_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  assign const_ext = WIDTH'(extend(ex_mode_t'(bus.ex_ctrl),
                                   EXT_MAX_W'(bus.ex_const), WIDTH, CONST_W));

  // Ready looks through a register that is being drained this cycle, so a
  // continuous stream runs with no bubble.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Data is only loaded on accept; when drained only valid drops, so a
  // stalled output ignores bank writes underneath it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      a_q     <= rd_a;
      b_q     <= rd_b;
      c_q     <= const_ext;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_const = c_q;

endmodule

// File: tb/tb_id_rf_stage.sv
// tb_id_rf_stage: self-checking bench for id_rf_stage (default widths).
// A behavioural model (register array + expected output register) is stepped
// alongside the DUT on every clock; directed scenarios use literal values.
module tb_id_rf_stage;
  import id_rf_pkg::*;

  localparam int W  = 16;
  localparam int NR = 8;
  localparam int CW = 11;
`ifdef ID_RF_R0_ZERO_EN
  localparam bit R0_ON = 1'b1;
`else
  localparam bit R0_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  id_rf_if #(.WIDTH(W), .NREGS(NR), .CONST_W(CW)) bus ();

  id_rf_stage #(.WIDTH(W), .NREGS(NR), .CONST_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] m_regs [NR];
  logic         exp_valid;
  logic [W-1:0] exp_a;
  logic [W-1:0] exp_b;
  logic [W-1:0] exp_c;

  // Extender reference written as integer arithmetic on the raw constant.
  function automatic logic [W-1:0] ref_extend(input int mode, input int c);
    int s;
    int r;
    s = (c >= 1024) ? c - 2048 : c;
    case (mode)
      0:       r = c;
      1:       r = s;
      2:       r = (c % 256) * 256;
      default: r = s * 2;
    endcase
    return r[15:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    exp_valid = 1'b0;
    exp_a = '0;
    exp_b = '0;
    exp_c = '0;
  endtask

  task automatic set_idle();
    bus.in_valid  = 1'b0;
    bus.sel_a     = '0;
    bus.sel_b     = '0;
    bus.ex_ctrl   = 2'b00;
    bus.ex_const  = '0;
    bus.wb_en     = 1'b0;
    bus.wb_sel    = '0;
    bus.wb_src_md = 1'b0;
    bus.wb_ula    = '0;
    bus.wb_md     = '0;
    bus.out_ready = 1'b1;
  endtask

  // One clock: apply the write to the model bank first, so a capture in the
  // same cycle naturally sees the written value; then advance the output.
  task automatic tick();
    logic [W-1:0] wd;
    logic         rdy;
    logic         cap;
    logic         ordy;
    int           sa, sb, md, cv;
    wd   = bus.wb_src_md ? bus.wb_md : bus.wb_ula;
    rdy  = !exp_valid || bus.out_ready;
    cap  = bus.in_valid && rdy;
    ordy = bus.out_ready;
    sa   = int'(bus.sel_a);
    sb   = int'(bus.sel_b);
    md   = int'(bus.ex_ctrl);
    cv   = int'(bus.ex_const);
    if (bus.wb_en && !(R0_ON && bus.wb_sel == 0)) m_regs[bus.wb_sel] = wd;
    @(posedge clock);
    #1;
    if (cap) begin
      exp_valid = 1'b1;
      exp_a = m_regs[sa];
      exp_b = m_regs[sb];
      exp_c = ref_extend(md, cv);
    end else if (ordy) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_valid got=%b want=0", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_a !== 16'h0 || bus.out_b !== 16'h0 || bus.out_const !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_data got=%h/%h/%h want=0", bus.out_a, bus.out_b, bus.out_const);
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_ready got=%b want=1", bus.in_ready);
    end
  endtask

  task automatic test_write_read();
    set_idle();
    bus.wb_en = 1'b1; bus.wb_sel = 3'd3; bus.wb_src_md = 1'b1;
    bus.wb_md = 16'hBEEF; bus.wb_ula = 16'h5555;
    tick();
    set_idle();
    bus.sel_a = 3'd3; bus.in_valid = 1'b1;
    tick();
    n_cmp++;
    if (bus.out_a !== 16'hBEEF || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL write_read got a=%h v=%b want a=beef v=1", bus.out_a, bus.out_valid);
    end
  endtask

  task automatic test_bypass();
    set_idle();
    bus.wb_en = 1'b1; bus.wb_sel = 3'd5; bus.wb_src_md = 1'b0;
    bus.wb_ula = 16'h1234; bus.wb_md = 16'h9999;
    bus.sel_a = 3'd5; bus.sel_b = 3'd5; bus.in_valid = 1'b1;
    tick();
    n_cmp++;
    if (bus.out_a !== 16'h1234 || bus.out_b !== 16'h1234) begin
      n_fail++;
      $display("[TB] FAIL bypass got a=%h b=%h want 1234", bus.out_a, bus.out_b);
    end
  endtask

  task automatic test_extender();
    logic [W-1:0] want [4];
    want[0] = 16'h07FF; want[1] = 16'hFFFF; want[2] = 16'hFF00; want[3] = 16'hFFFE;
    for (int m = 0; m < 4; m++) begin
      set_idle();
      bus.ex_const = 11'h7FF; bus.ex_ctrl = 2'(m); bus.in_valid = 1'b1;
      tick();
      n_cmp++;
      if (bus.out_const !== want[m]) begin
        n_fail++;
        $display("[TB] FAIL extend_mode%0d got=%h want=%h", m, bus.out_const, want[m]);
      end
    end
  endtask

  task automatic test_backpressure();
    set_idle();
    bus.sel_a = 3'd3; bus.wb_en = 1'b1; bus.wb_sel = 3'd3;
    bus.wb_src_md = 1'b0; bus.wb_ula = 16'hC0DE; bus.in_valid = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      set_idle();
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.sel_a = 3'd3;
      bus.wb_en = 1'b1; bus.wb_sel = 3'd3; bus.wb_ula = 16'(16'h1111 * (k + 1));
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stall_ready cyc%0d got=%b want=0", k, bus.in_ready);
      end
      tick();
      n_cmp++;
      if (bus.out_a !== 16'hC0DE || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL stall_hold cyc%0d got a=%h v=%b want a=c0de v=1", k, bus.out_a, bus.out_valid);
      end
    end
    set_idle();
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.sel_a = 3'd3;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL release_ready got=%b want=1", bus.in_ready);
    end
    tick();
    n_cmp++;
    if (bus.out_a !== 16'h3333 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL release_capture got a=%h v=%b want a=3333 v=1", bus.out_a, bus.out_valid);
    end
  endtask

  task automatic test_r0();
    logic [W-1:0] want;
    want = R0_ON ? 16'h0000 : 16'hAAAA;
    set_idle();
    bus.wb_en = 1'b1; bus.wb_sel = 3'd0; bus.wb_ula = 16'hAAAA;
    tick();
    set_idle();
    bus.sel_a = 3'd0; bus.in_valid = 1'b1;
    tick();
    n_cmp++;
    if (bus.out_a !== want) begin
      n_fail++;
      $display("[TB] FAIL r0_read got=%h want=%h", bus.out_a, want);
    end
  endtask

  task automatic test_reset_midstall();
    set_idle();
    bus.sel_a = 3'd3; bus.sel_b = 3'd5; bus.ex_const = 11'h155;
    bus.ex_ctrl = 2'b01; bus.in_valid = 1'b1;
    tick();
    set_idle();
    bus.out_ready = 1'b0;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== exp_a) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_stall got v=%b a=%h want v=1 a=%h", bus.out_valid, bus.out_a, exp_a);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_a !== 16'h0 || bus.out_b !== 16'h0 || bus.out_const !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL async_reset got v=%b %h/%h/%h want 0", bus.out_valid, bus.out_a, bus.out_b, bus.out_const);
    end
    #1 reset = 1'b0;
    for (int i = 0; i < NR; i++) begin
      set_idle();
      bus.sel_a = 3'(i); bus.sel_b = 3'(NR - 1 - i); bus.in_valid = 1'b1;
      tick();
      n_cmp++;
      if (bus.out_a !== 16'h0 || bus.out_b !== 16'h0) begin
        n_fail++;
        $display("[TB] FAIL reg_cleared r%0d got a=%h b=%h want 0", i, bus.out_a, bus.out_b);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.in_valid  = 1'($urandom_range(0, 3) != 0);
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      bus.sel_a     = 3'($urandom_range(0, NR - 1));
      bus.sel_b     = 3'($urandom_range(0, NR - 1));
      bus.ex_ctrl   = 2'($urandom_range(0, 3));
      bus.ex_const  = 11'($urandom_range(0, 2047));
      bus.wb_en     = 1'($urandom_range(0, 1));
      bus.wb_sel    = 3'($urandom_range(0, NR - 1));
      bus.wb_src_md = 1'($urandom_range(0, 1));
      bus.wb_ula    = 16'($urandom);
      bus.wb_md     = 16'($urandom);
      #1;
      n_cmp++;
      if (bus.in_ready !== (!exp_valid || bus.out_ready)) begin
        n_fail++;
        $display("[TB] FAIL rand_ready n=%0d got=%b want=%b", n, bus.in_ready, !exp_valid || bus.out_ready);
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== exp_valid || bus.out_a !== exp_a || bus.out_b !== exp_b || bus.out_const !== exp_c) begin
        n_fail++;
        $display("[TB] FAIL rand_out n=%0d got v=%b %h/%h/%h want v=%b %h/%h/%h", n,
                 bus.out_valid, bus.out_a, bus.out_b, bus.out_const, exp_valid, exp_a, exp_b, exp_c);
      end
    end
  endtask

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_write_read();
    test_bypass();
    test_extender();
    test_backpressure();
    test_r0();
    test_reset_midstall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
